// File: rtl/cpu_pkg.sv
// Shared definitions for the write-back destination path: destination
// selector codes, the hard-wired zero register and the in-flight entry layout.
package cpu_pkg;

   localparam logic [1:0] DST_RD   = 2'b00;
   localparam logic [1:0] DST_RT   = 2'b01;
   localparam logic [1:0] DST_LINK = 2'b10;
   localparam logic [1:0] DST_NONE = 2'b11;

   localparam int REG_ZERO = 0;

   // Entry layout at the default register-file geometry (32 x 32-bit).
   localparam int ENTRY_ADDR_W = 5;
   localparam int ENTRY_DATA_W = 32;

   typedef struct packed {
      logic                    valid;
      logic [ENTRY_ADDR_W-1:0] addr;
      logic [ENTRY_DATA_W-1:0] data;
   } entry_t;

endpackage

// File: rtl/wb_fwd_match.sv
// DEPTH-way priority comparator: reports whether any valid in-flight entry
// targets rd_addr and returns the data of the youngest such entry (index 0).
module wb_fwd_match
   import cpu_pkg::*;
#(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32,
   parameter int DEPTH  = 3
) (
   input  logic [DEPTH-1:0]        ent_valid,
   input  logic [DEPTH*ADDR_W-1:0] ent_addr,
   input  logic [DEPTH*DATA_W-1:0] ent_data,
   input  logic [ADDR_W-1:0]       rd_addr,
   output logic                    hit,
   output logic [DATA_W-1:0]       fwd_data
);

   always_comb begin
      hit      = 1'b0;
      fwd_data = '0;
      if (rd_addr != ADDR_W'(REG_ZERO)) begin
         // Walk oldest to youngest so the youngest match overwrites last.
         for (int i = DEPTH - 1; i >= 0; i--) begin
            if (ent_valid[i] && (ent_addr[i*ADDR_W +: ADDR_W] == rd_addr)) begin
               hit      = 1'b1;
               fwd_data = ent_data[i*DATA_W +: DATA_W];
            end
         end
      end
   end

endmodule

// File: rtl/wb_dest_pipe.sv
// Write-back destination stage: resolves the destination register, carries it
// through DEPTH stages to the regfile port and exposes in-flight writes.
module wb_dest_pipe
   import cpu_pkg::*;
#(
   parameter int ADDR_W   = 5,
   parameter int DATA_W   = 32,
   parameter int DEPTH    = 3,
   parameter int LINK_REG = 31
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [ADDR_W-1:0] in_rt,
   input  logic [ADDR_W-1:0] in_rd,
   input  logic [1:0]        in_dst_sel,
   input  logic [DATA_W-1:0] in_data,
   input  logic              stall,
   input  logic              flush,
   input  logic [ADDR_W-1:0] rd_a,
   input  logic [ADDR_W-1:0] rd_b,
   output logic              hazard_a,
   output logic              hazard_b,
   output logic [DATA_W-1:0] fwd_data_a,
   output logic [DATA_W-1:0] fwd_data_b,
   output logic              rf_we,
   output logic [ADDR_W-1:0] rf_waddr,
   output logic [DATA_W-1:0] rf_wdata
);

   // Internal stages sit in front of the rf_* register; DEPTH=1 has none,
   // so a single unused slot keeps the array legal.
   localparam int NI   = (DEPTH > 1) ? DEPTH - 1 : 1;
   localparam int LAST = NI - 1;

   typedef struct packed {
      logic              valid;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } stage_t;

   stage_t stg_q [NI];
   stage_t stg_d [NI];
   stage_t issue;
   stage_t tail;

   logic              rf_we_d,    rf_we_q;
   logic [ADDR_W-1:0] rf_waddr_d, rf_waddr_q;
   logic [DATA_W-1:0] rf_wdata_d, rf_wdata_q;
   logic [ADDR_W-1:0] dec_addr;

   always_comb begin
      case (in_dst_sel)
         DST_RD:   dec_addr = in_rd;
         DST_RT:   dec_addr = in_rt;
         DST_LINK: dec_addr = ADDR_W'(LINK_REG);
         default:  dec_addr = '0;
      endcase
      issue.valid = in_valid && (in_dst_sel != DST_NONE) &&
                    (dec_addr != ADDR_W'(REG_ZERO));
      issue.addr  = dec_addr;
      issue.data  = in_data;
   end

   always_comb begin
      for (int i = 0; i < NI; i++) stg_d[i] = stg_q[i];
      rf_we_d    = 1'b0;
      rf_waddr_d = rf_waddr_q;
      rf_wdata_d = rf_wdata_q;
      tail       = (DEPTH > 1) ? stg_q[LAST] : issue;
      if (flush) begin
         for (int i = 0; i < NI; i++) stg_d[i].valid = 1'b0;
      end else if (!stall) begin
         rf_we_d = tail.valid;
         if (tail.valid) begin
            rf_waddr_d = tail.addr;
            rf_wdata_d = tail.data;
         end
         for (int i = NI - 1; i > 0; i--) stg_d[i] = stg_q[i-1];
         stg_d[0] = issue;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NI; i++) stg_q[i] <= '0;
         rf_we_q    <= 1'b0;
         rf_waddr_q <= '0;
         rf_wdata_q <= '0;
      end else begin
         for (int i = 0; i < NI; i++) stg_q[i] <= stg_d[i];
         rf_we_q    <= rf_we_d;
         rf_waddr_q <= rf_waddr_d;
         rf_wdata_q <= rf_wdata_d;
      end
   end

   assign rf_we    = rf_we_q;
   assign rf_waddr = rf_waddr_q;
   assign rf_wdata = rf_wdata_q;

   // Scoreboard view: index 0 is the youngest stage, DEPTH-1 the rf_* register.
   logic [DEPTH-1:0]        m_valid;
   logic [DEPTH*ADDR_W-1:0] m_addr;
   logic [DEPTH*DATA_W-1:0] m_data;

   always_comb begin
      m_valid = '0;
      m_addr  = '0;
      m_data  = '0;
      for (int i = 0; i < DEPTH - 1; i++) begin
         m_valid[i]                  = stg_q[i].valid;
         m_addr[i*ADDR_W +: ADDR_W]  = stg_q[i].addr;
         m_data[i*DATA_W +: DATA_W]  = stg_q[i].data;
      end
      m_valid[DEPTH-1]                     = rf_we_q;
      m_addr[(DEPTH-1)*ADDR_W +: ADDR_W]   = rf_waddr_q;
      m_data[(DEPTH-1)*DATA_W +: DATA_W]   = rf_wdata_q;
   end

   wb_fwd_match #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) u_match_a (
      .ent_valid (m_valid),
      .ent_addr  (m_addr),
      .ent_data  (m_data),
      .rd_addr   (rd_a),
      .hit       (hazard_a),
      .fwd_data  (fwd_data_a)
   );

   wb_fwd_match #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) u_match_b (
      .ent_valid (m_valid),
      .ent_addr  (m_addr),
      .ent_data  (m_data),
      .rd_addr   (rd_b),
      .hit       (hazard_b),
      .fwd_data  (fwd_data_b)
   );

endmodule
